// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - 1-to-2 registered stream demultiplexer with per-port holding registers
module stream_demux_1to2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic              full0_q, full0_d;
    logic              full1_q, full1_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic acc;
    logic acc0;
    logic acc1;
    logic drain0;
    logic drain1;

    always_comb begin
        drain0 = full0_q & out0_ready;
        drain1 = full1_q & out1_ready;
        // A full port still accepts when its consumer drains in the same cycle.
        if (in_sel) begin
            in_ready = ~flush & (~full1_q | out1_ready);
        end else begin
            in_ready = ~flush & (~full0_q | out0_ready);
        end
        acc  = in_valid & in_ready;
        acc0 = acc & ~in_sel;
        acc1 = acc & in_sel;
    end

    always_comb begin
        full0_d = full0_q;
        full1_d = full1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        if (flush) begin
            full0_d = 1'b0;
        end else if (acc0) begin
            full0_d = 1'b1;
        end else if (drain0) begin
            full0_d = 1'b0;
        end

        if (flush) begin
            full1_d = 1'b0;
        end else if (acc1) begin
            full1_d = 1'b1;
        end else if (drain1) begin
            full1_d = 1'b0;
        end

        if (acc0) begin
            data0_d = in_data;
        end
        if (acc1) begin
            data1_d = in_data;
        end

        // Drains during a flush cycle still count: the consumer took the data.
        if (drain0) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (drain1) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign out0_valid = full0_q;
    assign out1_valid = full1_q;
    assign out0_data  = data0_q;
    assign out1_data  = data1_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb/tb_stream_demux_1to2.sv - scoreboard bench for stream_demux_1to2
module tb_stream_demux_1to2;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];

    stream_demux_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sel, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: beat %h never accepted, required acceptance within 20 cycles", d);
        end
    endtask

    // Scoreboard monitor: compares every handshake that will complete at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_unexpected: got %h expected no beat", out0_data);
                end else begin
                    logic [31:0] e0;
                    e0 = q0.pop_front();
                    if (out0_data !== e0) begin
                        errors++;
                        $display("FAIL out0_data: got %h expected %h", out0_data, e0);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected: got %h expected no beat", out1_data);
                end else begin
                    logic [31:0] e1;
                    e1 = q1.pop_front();
                    if (out1_data !== e1) begin
                        errors++;
                        $display("FAIL out1_data: got %h expected %h", out1_data, e1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #23;
        chk("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("rst_out0_data", out0_data, 32'd0);
        chk("rst_cnt0", {28'b0, cnt0}, 32'd0);
        chk("rst_cnt1", {28'b0, cnt1}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single beat to port 0
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(1'b0, 32'hDEADBEEF);
        chk("t1_out0_valid", {31'b0, out0_valid}, 32'd1);
        chk("t1_out0_data", out0_data, 32'hDEADBEEF);
        chk("t1_out1_valid", {31'b0, out1_valid}, 32'd0);
        step();
        chk("t1_cnt0", {28'b0, cnt0}, 32'd1);
        chk("t1_out0_valid_after", {31'b0, out0_valid}, 32'd0);

        // 2: stalled port 0 blocks only beats for port 0
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 32'hA1A1A1A1);
        in_sel   = 1'b0;
        in_data  = 32'hA2A2A2A2;
        in_valid = 1'b1;
        #1;
        chk("t2_in_ready_blocked", {31'b0, in_ready}, 32'd0);
        step();
        chk("t2_in_ready_still_blocked", {31'b0, in_ready}, 32'd0);
        chk("t2_out0_held", out0_data, 32'hA1A1A1A1);
        send(1'b1, 32'hB1B1B1B1);
        chk("t2_out1_valid", {31'b0, out1_valid}, 32'd1);
        chk("t2_out1_data", out1_data, 32'hB1B1B1B1);
        chk("t2_out0_still_held", out0_data, 32'hA1A1A1A1);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        chk("t2_cnt0", {28'b0, cnt0}, 32'd2);
        chk("t2_cnt1", {28'b0, cnt1}, 32'd1);

        // 3: streaming 1..8 into port 1
        in_sel   = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = i;
            @(negedge clk);
            chk("t3_in_ready", {31'b0, in_ready}, 32'd1);
            q1.push_back(i);
            @(posedge clk);
            #1;
            chk("t3_out1_valid", {31'b0, out1_valid}, 32'd1);
            chk("t3_out1_data", out1_data, i);
        end
        in_valid = 1'b0;
        step();
        chk("t3_cnt1", {28'b0, cnt1}, 32'd9);
        chk("t3_out1_empty", {31'b0, out1_valid}, 32'd0);

        // 4: drain and load on the same cycle
        out0_ready = 1'b0;
        send(1'b0, 32'hC1C1C1C1);
        out0_ready = 1'b1;
        send(1'b0, 32'hC2C2C2C2);
        chk("t4_out0_valid", {31'b0, out0_valid}, 32'd1);
        chk("t4_out0_data", out0_data, 32'hC2C2C2C2);
        chk("t4_cnt0", {28'b0, cnt0}, 32'd3);
        step();
        chk("t4_cnt0_after", {28'b0, cnt0}, 32'd4);

        // 5: flush with both ports full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 32'hD0D0D0D0);
        send(1'b1, 32'hD1D1D1D1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hEEEEEEEE;
        out1_ready = 1'b0;
        #1;
        chk("t5_in_ready_flush", {31'b0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        chk("t5_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("t5_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("t5_cnt0", {28'b0, cnt0}, 32'd4);
        chk("t5_cnt1", {28'b0, cnt1}, 32'd9);

        // 6: counter wrap after fresh reset, then async reset mid-transfer
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        out0_ready = 1'b1;
        in_sel     = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'h100 + i;
            @(negedge clk);
            chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
            q0.push_back(32'h100 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        step();
        chk("t6_cnt0_wrap", {28'b0, cnt0}, 32'd1);

        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 32'hF0F0F0F0);
        send(1'b1, 32'hF1F1F1F1);
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("t6_rst_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("t6_rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("t6_rst_out0_data", out0_data, 32'd0);
        chk("t6_rst_out1_data", out1_data, 32'd0);
        chk("t6_rst_cnt0", {28'b0, cnt0}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        chk("end_q0_empty", q0.size(), 32'd0);
        chk("end_q1_empty", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
